servo_bank: RTL and testbench

- Multi-channel successor to the single-servo controller.
- Drives NUM_CHANNELS hobby-servo PWM outputs from one shared prescaler and one shared 20 ms frame counter.
- Each channel has an 8-bit target position; slew-rate limiting is programmable; enables are per channel.
- Sits on the SoC peripheral bus as a memory-mapped slave using the same din/address/w_en/r_en/dout convention as the other peripherals.

---
 rtl/servo_bank.sv | 121 ++++++++++++
 tb/tb_servo_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_bank.sv
// Multi-channel hobby-servo PWM bank with shared prescaler/frame counter and per-frame slew limiting.
// Optional macro SERVO_BANK_READBACK_EN maps read-only CURRENT[i] registers after the TARGET block.
module servo_bank #(
   parameter logic [7:0]  BASE_ADDRESS = 8'h00,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned CLK_FREQ     = 16000000,
   parameter int unsigned TICK_NS      = 6350,
   parameter int unsigned PERIOD_TICKS = 3150,
   parameter int unsigned MIN_TICKS    = 91
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              din,
   input  logic [7:0]              address,
   input  logic                    w_en,
   input  logic                    r_en,
   output logic [7:0]              dout,
   output logic [NUM_CHANNELS-1:0] servo_pin
);

   localparam longint unsigned PRESCALE_L =
      (64'(TICK_NS) * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000;
   localparam int unsigned PRESCALE = 32'(PRESCALE_L);
   localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CW       = $clog2(PERIOD_TICKS);

   generate
      if (MIN_TICKS + 255 >= PERIOD_TICKS) begin : g_bad_period
         $error("servo_bank: MIN_TICKS+255 must be below PERIOD_TICKS");
      end
      if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
         $error("servo_bank: NUM_CHANNELS must be 1..8");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("servo_bank: prescale must be at least 1");
      end
   endgenerate

   logic [NUM_CHANNELS-1:0] ctrl;
   logic [NUM_CHANNELS-1:0] active_en;
   logic [7:0]              slew;
   logic [7:0]              target  [NUM_CHANNELS];
   logic [7:0]              current [NUM_CHANNELS];
   logic [PW-1:0]           presc;
   logic [CW-1:0]           frame_cnt;

   logic [8:0] off_c;
   logic       tick_c;
   logic       frame_end_c;
   logic [7:0] rd_data_c;

   // Offset is 9 bits so addresses below BASE_ADDRESS land above any mapped offset
   assign off_c       = {1'b0, address} - {1'b0, BASE_ADDRESS};
   assign tick_c      = (presc == PW'(PRESCALE - 1));
   assign frame_end_c = tick_c && (frame_cnt == CW'(PERIOD_TICKS - 1));

   // Step cur toward tgt by at most step; step of zero jumps straight to tgt
   function automatic logic [7:0] next_pos(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] step);
      logic signed [8:0] diff;
      logic [8:0]        mag;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      mag  = diff[8] ? 9'(-diff) : 9'(diff);
      if (step == 8'd0 || mag <= {1'b0, step}) next_pos = tgt;
      else if (diff[8])                        next_pos = cur - step;
      else                                     next_pos = cur + step;
   endfunction

   // Read data mux
   always_comb begin
      rd_data_c = '0;
      if (off_c == 9'd0) rd_data_c = 8'(ctrl);
      if (off_c == 9'd1) rd_data_c = slew;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         if (off_c == 9'(2 + i)) rd_data_c = target[i];
`ifdef SERVO_BANK_READBACK_EN
         if (off_c == 9'(2 + NUM_CHANNELS + i)) rd_data_c = current[i];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl      <= '0;
         active_en <= '0;
         slew      <= '0;
         presc     <= '0;
         frame_cnt <= '0;
         dout      <= '0;
         servo_pin <= '0;
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            target[i]  <= '0;
            current[i] <= '0;
         end
      end else begin
         presc <= tick_c ? '0 : presc + PW'(1);
         if (tick_c) frame_cnt <= frame_end_c ? '0 : frame_cnt + CW'(1);

         // Enables and positions only move at the frame boundary to avoid runt pulses
         if (frame_end_c) begin
            active_en <= ctrl;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++)
               current[i] <= next_pos(current[i], target[i], slew);
         end

         if (w_en) begin
            if (off_c == 9'd0) ctrl <= din[NUM_CHANNELS-1:0];
            if (off_c == 9'd1) slew <= din;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++)
               if (off_c == 9'(2 + i)) target[i] <= din;
         end

         if (r_en) dout <= rd_data_c;

         for (int unsigned i = 0; i < NUM_CHANNELS; i++)
            servo_pin[i] <= active_en[i] &&
                            (frame_cnt < CW'(MIN_TICKS) + CW'(current[i]));
      end
   end

endmodule

// File: tb/tb_servo_bank.sv
// Self-checking bench for servo_bank: per-frame pulse widths and bus reads checked against a frame-level model.
module tb_servo_bank;

   localparam logic [7:0] BASE    = 8'h10;
   localparam int NCH             = 4;
   localparam int CLK_HZ          = 16000000;
   localparam int TICK            = 150;
   localparam int PERIOD          = 300;
   localparam int MINT            = 4;
   localparam longint P_L         = (longint'(TICK) * longint'(CLK_HZ) + 64'd999999999) / 64'd1000000000;
   localparam int P               = int'(P_L);
   localparam int FRAME           = P * PERIOD;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       din;
   logic [7:0]       address;
   logic             w_en;
   logic             r_en;
   logic [7:0]       dout;
   logic [NCH-1:0]   servo_pin;

   servo_bank #(
      .BASE_ADDRESS(BASE), .NUM_CHANNELS(NCH), .CLK_FREQ(CLK_HZ),
      .TICK_NS(TICK), .PERIOD_TICKS(PERIOD), .MIN_TICKS(MINT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .address(address),
      .w_en(w_en), .r_en(r_en), .dout(dout), .servo_pin(servo_pin)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int pos    = 0;
   int frame  = 0;
   int hi_cnt [NCH];

   // Model state: programmed registers plus what the current frame is using
   int ctrl_m, slew_m;
   int tgt_m [NCH];
   int cur_m [NCH];
   int en_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      ctrl_m = 0; slew_m = 0; en_m = 0;
      for (int c = 0; c < NCH; c++) begin tgt_m[c] = 0; cur_m[c] = 0; hi_cnt[c] = 0; end
      pos = 0;
   endtask

   task automatic model_write(input int a, input int d);
      int off;
      off = a - int'(BASE);
      if (off == 0) ctrl_m = d & ((1 << NCH) - 1);
      else if (off == 1) slew_m = d;
      else if (off >= 2 && off < 2 + NCH) tgt_m[off-2] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pos++;
      for (int c = 0; c < NCH; c++) if (servo_pin[c] === 1'b1) hi_cnt[c]++;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      address = a; din = d; w_en = 1'b1;
      step();
      w_en = 1'b0;
      model_write(int'(a), int'(d));
   endtask

   task automatic bus_read(input logic [7:0] a, input int exp, input string tag);
      address = a; r_en = 1'b1;
      step();
      r_en = 1'b0;
      check(tag, 32'(dout), 32'(exp));
   endtask

   // Run to the end of the frame, check each pulse width, then apply the boundary rules
   task automatic finish_window();
      int d;
      while (pos < FRAME) step();
      for (int c = 0; c < NCH; c++)
         check($sformatf("pw_f%0d_ch%0d", frame, c), 32'(hi_cnt[c]),
               32'(((en_m >> c) & 1) != 0 ? (MINT + cur_m[c]) * P : 0));
      en_m = ctrl_m;
      for (int c = 0; c < NCH; c++) begin
         d = tgt_m[c] - cur_m[c];
         if (slew_m == 0 || (d <= slew_m && d >= -slew_m)) cur_m[c] = tgt_m[c];
         else if (d > 0) cur_m[c] = cur_m[c] + slew_m;
         else cur_m[c] = cur_m[c] - slew_m;
         hi_cnt[c] = 0;
      end
      pos = 0;
      frame++;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) step();
      check("reset_pins", 32'(servo_pin), 32'd0);
      check("reset_dout", 32'(dout), 32'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   int old_slew, exp_rb;

   initial begin
      rst_n = 1'b0; din = '0; address = '0; w_en = 1'b0; r_en = 1'b0;
      model_reset();

      // Reset then idle
      do_reset(4);
      finish_window();
      bus_read(BASE + 8'd0, 0, "idle_ctrl");
      bus_read(BASE + 8'd1, 0, "idle_slew");
      bus_read(BASE + 8'd2, 0, "idle_tgt0");
      finish_window();

      // Basic PWM: minimum then maximum position
      bus_write(BASE + 8'd0, 8'h01);
      bus_write(BASE + 8'd2, 8'd0);
      finish_window();
      finish_window();
      bus_write(BASE + 8'd2, 8'd255);
      finish_window();
      finish_window();

      // Slew limiting 0 -> 35 in steps of 10
      bus_write(BASE + 8'd2, 8'd0);
      finish_window();
      bus_write(BASE + 8'd1, 8'd10);
      bus_write(BASE + 8'd2, 8'd35);
      repeat (6) finish_window();

      // Mid-frame target write lands in the next frame only
      bus_write(BASE + 8'd0, 8'h02);
      bus_write(BASE + 8'd1, 8'd0);
      finish_window();
      while (pos < 150 * P) step();
      bus_write(BASE + 8'd3, 8'd200);
      finish_window();
      finish_window();

      // Randomized register traffic at random points within frames
      for (int k = 0; k < 6; k++) begin
         while (pos < int'($urandom_range(1, 500))) step();
         bus_write(BASE + 8'd0, 8'($urandom));
         bus_write(BASE + 8'd1, ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 80)));
         for (int c = 0; c < NCH; c++) bus_write(BASE + 8'(2 + c), 8'($urandom));
         bus_write(BASE + 8'(2 + NCH), 8'h77);
         finish_window();
      end
      finish_window();

      // Bus edge cases
`ifdef SERVO_BANK_READBACK_EN
      exp_rb = cur_m[0];
`else
      exp_rb = 0;
`endif
      bus_read(BASE + 8'(2 + NCH), exp_rb, "rd_past_targets");
      bus_read(8'h05, 0, "rd_below_base");
      bus_read(8'hF0, 0, "rd_far_unmapped");
      for (int c = 0; c < NCH; c++)
         bus_read(BASE + 8'(2 + c), tgt_m[c], $sformatf("rd_tgt%0d", c));
      bus_write(BASE + 8'd0, 8'hFF);
      bus_read(BASE + 8'd0, 8'h0F, "ctrl_mask");
      step();
      check("dout_hold", 32'(dout), 32'h0F);
      old_slew = slew_m;
      address = BASE + 8'd1; din = 8'h55; w_en = 1'b1; r_en = 1'b1;
      step();
      w_en = 1'b0; r_en = 1'b0;
      model_write(int'(BASE) + 1, 8'h55);
      check("rw_same_old", 32'(dout), 32'(old_slew));
      bus_read(BASE + 8'd1, 8'h55, "rw_same_new");
      finish_window();

      // Reset while channel 0 pulse is high
      bus_write(BASE + 8'd0, 8'h01);
      bus_write(BASE + 8'd1, 8'd0);
      bus_write(BASE + 8'd2, 8'd100);
      finish_window();
      while (pos < 20) step();
      check("pre_reset_pin0", 32'(servo_pin[0]), 32'd1);
      rst_n = 1'b0;
      step();
      check("reset_truncates", 32'(servo_pin), 32'd0);
      do_reset(3);
      for (int a = 0; a < 2 + 2 * NCH; a++)
         bus_read(BASE + 8'(a), 0, $sformatf("post_reset_r%0d", a));
      bus_write(BASE + 8'd0, 8'h01);
      finish_window();
      finish_window();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
